// File: rtl/hilo_divider_if.sv
// Execute-stage <-> divider handshake plus the result/write-enable bundle
// feeding the enable-gated HI/LO registers.
interface hilo_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] hi_out;
  logic             lo_en;
  logic             hi_en;

  modport master (
    output start, is_signed, opA, opB,
    input  stall, busy, done, lo_out, hi_out, lo_en, hi_en
  );

  modport slave (
    input  start, is_signed, opA, opB,
    output stall, busy, done, lo_out, hi_out, lo_en, hi_en
  );
endinterface

// File: rtl/hilo_divider.sv
// Iterative restoring divider producing quotient (LO) and remainder (HI)
// with one-cycle write-enable pulses; stalls the pipeline while running.
module hilo_divider #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic          clk,
  input  logic          resetn,
  hilo_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t           state;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] raw_a;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] sub;
  logic             take;

  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn & v[WIDTH-1]) ? neg2(v) : v;
  endfunction

  // (WIDTH+1)-bit trial: since rem < dvs, a set top bit of the shifted
  // partial always exceeds the divisor, and the difference fits in WIDTH bits.
  assign partial = {rem, quo[WIDTH-1]};
  assign take    = partial[WIDTH] | (partial[WIDTH-1:0] >= dvs);
  assign sub     = partial[WIDTH-1:0] - dvs;

  assign bus.stall  = (bus.start & (state == IDLE)) | busy_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.lo_en  = done_r;
  assign bus.hi_en  = done_r;
  assign bus.lo_out = lo_r;
  assign bus.hi_out = hi_r;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      raw_a  <= '0;
      lo_r   <= '0;
      hi_r   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            quo    <= mag(bus.opA, bus.is_signed);
            dvs    <= mag(bus.opB, bus.is_signed);
            rem    <= '0;
            neg_q  <= bus.is_signed & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
            neg_r  <= bus.is_signed & bus.opA[WIDTH-1];
            div0   <= (bus.opB == '0);
            raw_a  <= bus.opA;
            cnt    <= CNTW'(WIDTH);
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          rem <= take ? sub : partial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], take};
          cnt <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) state <= FIX;
        end
        FIX: begin
          // Divide-by-zero reports all-ones / raw dividend regardless of signedness.
          if (div0) begin
            lo_r <= '1;
            hi_r <= raw_a;
          end else begin
            lo_r <= neg_q ? neg2(quo) : quo;
            hi_r <= neg_r ? neg2(rem) : rem;
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_divider.sv
// Bench for hilo_divider: directed vector table, back-to-back, ignored
// start, mid-operation reset and randomized operands against a model.
module tb_hilo_divider;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  hilo_divider_if #(.WIDTH(W)) bus ();

  hilo_divider #(.WIDTH(W), .CNTW(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          sgn;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  lo;
    logic [W-1:0]  hi;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Plain-arithmetic reference: truncating division, remainder follows dividend.
  task automatic ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] lo, output logic [W-1:0] hi);
    longint sa, sb, q, r;
    if (b == 0) begin
      lo = '1;
      hi = a;
    end else begin
      sa = sgn ? longint'($signed(a)) : longint'(a);
      sb = sgn ? longint'($signed(b)) : longint'(b);
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
    end
  endtask

  // Called in cycle 0 (before its rising edge). Checks handshake outputs every
  // cycle through the done cycle and returns at the done-cycle negedge.
  // poke>0 re-asserts start with junk operands in that cycle.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke, output logic [W-1:0] lo, output logic [W-1:0] hi);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.opA       = a;
    bus.opB       = b;
    lo = '0;
    hi = '0;
    #1;
    for (int c = 0; c <= LAT; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("stall@%0d", c), 64'(bus.stall), 64'(c <= LAT - 1));
      chk($sformatf("busy@%0d", c), 64'(bus.busy), 64'(c >= 1 && c <= LAT - 1));
      if (c > 0) begin
        chk($sformatf("done@%0d", c), 64'(bus.done), 64'(c == LAT));
        chk($sformatf("lo_en@%0d", c), 64'(bus.lo_en), 64'(c == LAT));
        chk($sformatf("hi_en@%0d", c), 64'(bus.hi_en), 64'(c == LAT));
      end
      if (c == LAT) begin
        lo = bus.lo_out;
        hi = bus.hi_out;
      end
      if (poke > 0 && c == poke) begin
        bus.start     = 1'b1;
        bus.is_signed = ~sgn;
        bus.opA       = $urandom;
        bus.opB       = $urandom_range(1, 9);
      end
      if (poke > 0 && c == poke + 1) bus.start = 1'b0;
      if (c == 0) begin
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.opA   = $urandom;
        bus.opB   = $urandom;
      end
    end
  endtask

  logic [W-1:0] lo, hi, elo, ehi, ra, rb;
  logic         rs;
  int           pulses;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{1'b0, 32'hFFFFFFF9,   32'h2,        32'h7FFFFFFC, 32'h1};
    vecs[3] = '{1'b1, 32'hFFFFFFFB,   32'h0,        32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[4] = '{1'b0, 32'd5,          32'h0,        32'hFFFFFFFF, 32'd5};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[6] = '{1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD, 32'd2,        32'hFFFFFFFE};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        32'd0};
    vecs[8] = '{1'b0, 32'd3,          32'd10,       32'd0,        32'd3};
    vecs[9] = '{1'b1, 32'h80000000,   32'd1,        32'h80000000, 32'd0};

    resetn        = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.opA       = '0;
    bus.opB       = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_busy",  64'(bus.busy),   64'd0);
    chk("rst_done",  64'(bus.done),   64'd0);
    chk("rst_stall", 64'(bus.stall),  64'd0);
    chk("rst_lo_en", 64'(bus.lo_en),  64'd0);
    chk("rst_lo",    64'(bus.lo_out), 64'd0);
    chk("rst_hi",    64'(bus.hi_out), 64'd0);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, -1, lo, hi);
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
    end

    // Overflow case, then a new start issued in its done cycle.
    @(posedge clk);
    #1;
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, lo, hi);
    chk("ovf_lo", 64'(lo), 64'h80000000);
    chk("ovf_hi", 64'(hi), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, -1, lo, hi);
    chk("b2b_lo", 64'(lo), 64'd3);
    chk("b2b_hi", 64'(hi), 64'd0);

    // start while busy must be ignored.
    @(posedge clk);
    #1;
    run_div(1'b0, 32'd100, 32'd7, 5, lo, hi);
    chk("poke_lo", 64'(lo), 64'd14);
    chk("poke_hi", 64'(hi), 64'd2);
    @(negedge clk);
    chk("poke_done_after", 64'(bus.done),   64'd0);
    chk("poke_lo_hold",    64'(bus.lo_out), 64'd14);
    chk("poke_busy_after", 64'(bus.busy),   64'd0);

    // Reset at the cycle-10 edge of a division.
    @(posedge clk);
    #1;
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.opA = 32'd1000; bus.opB = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",  64'(bus.busy),   64'd0);
    chk("mid_rst_stall", 64'(bus.stall),  64'd0);
    chk("mid_rst_done",  64'(bus.done),   64'd0);
    chk("mid_rst_lo",    64'(bus.lo_out), 64'd0);
    chk("mid_rst_hi",    64'(bus.hi_out), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("mid_rst_pulses", 64'(pulses), 64'd0);
    @(posedge clk);
    #1;
    run_div(1'b0, 32'd1000, 32'd3, -1, lo, hi);
    chk("post_rst_lo", 64'(lo), 64'd333);
    chk("post_rst_hi", 64'(hi), 64'd1);

    // Randomized operands against the reference model.
    for (int i = 0; i < 60; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 9) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = '1;
        default: rb = 32'($urandom) >> $urandom_range(0, 31);
      endcase
      ref_div(rs, ra, rb, elo, ehi);
      @(posedge clk);
      #1;
      run_div(rs, ra, rb, -1, lo, hi);
      chk($sformatf("rnd%0d_lo s=%0d a=%h b=%h", i, rs, ra, rb), 64'(lo), 64'(elo));
      chk($sformatf("rnd%0d_hi s=%0d a=%h b=%h", i, rs, ra, rb), 64'(hi), 64'(ehi));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
